// File: rtl/spi_pkg.sv
// spi_pkg: shared types, constants and bit helpers for the SPI target port.
//   spi_state_e          : frame state (IDLE / ACTIVE)
//   MODE0..MODE3         : SPI mode encoding as {cpol, cpha}
//   BIT_CNT_W            : width of the per-byte bit counter
//   DEFAULT_SYNC_STAGES  : default synchronizer depth on the SPI inputs
// Optional feature macro used by the port: SPI_SLAVE_OVERRUN_EN.

package spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int BIT_CNT_W           = 3;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Bit that goes on the wire first for the selected bit order.
    function automatic logic first_bit(input logic [7:0] d, input logic lsb_first);
        return lsb_first ? d[0] : d[7];
    endfunction

    // Drop the bit just transmitted, bringing the next one into first position.
    function automatic logic [7:0] shift_out(input logic [7:0] d, input logic lsb_first);
        return lsb_first ? {1'b0, d[7:1]} : {d[6:0], 1'b0};
    endfunction

    // Insert a received bit so that after 8 samples the byte is in natural order.
    function automatic logic [7:0] shift_in(input logic [7:0] d, input logic b,
                                            input logic lsb_first);
        return lsb_first ? {b, d[7:1]} : {d[6:0], b};
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// spi_input_sync: multi-flop synchronizer with rise/fall pulse outputs.
// Ports:
//   PCLK, PRESETn : clock, synchronous active-low reset
//   din           : asynchronous input
//   level         : synchronized level (STAGES flops after din)
//   rise, fall    : single-cycle pulses on a change of the synchronized level
// RESET_VAL sets what the chain assumes the input was during reset; choosing
// the active level for ss means a line held low through reset produces no
// falling edge afterwards.

module spi_input_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI target port, fully oversampled in the PCLK domain.
// Ports:
//   PCLK, PRESETn              : only clock, synchronous active-low reset
//   cpol, cpha, lsbfe          : mode and bit order, captured at frame start
//   sclk, ss, mosi             : asynchronous SPI inputs (ss active-low)
//   miso, miso_oe              : serial output and pad enable (= busy)
//   tx_data/tx_valid/tx_ready  : one-entry TX holding register write port
//   rx_data/rx_valid/rx_ready  : received byte handshake
//   rx_overrun, clr_overrun    : sticky overrun flag and its clear
//   busy                       : frame active
// Build option: define SPI_SLAVE_OVERRUN_EN to drop bytes that complete while
// rx_valid is still pending and flag rx_overrun; otherwise new bytes overwrite
// rx_data and rx_overrun stays 0.
// SYNC_STAGES must be at least 2.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | ss high; miso driven 0, waiting for a fresh ss fall
// ST_ACTIVE | frame in progress; sampling mosi and shifting miso

module spi_slave_port
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       cpol,
    input  logic       cpha,
    input  logic       lsbfe,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_overrun,
    input  logic       clr_overrun,
    output logic       busy
);

    localparam logic [BIT_CNT_W-1:0] BIT_LAST = '1;

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic ss_level_unused, ss_rise, ss_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .din     (sclk),
        .level   (sclk_level_unused),
        .rise    (sclk_rise),
        .fall    (sclk_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_ss (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .din     (ss),
        .level   (ss_level_unused),
        .rise    (ss_rise),
        .fall    (ss_fall)
    );

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .din     (mosi),
        .level   (mosi_s),
        .rise    (mosi_rise_unused),
        .fall    (mosi_fall_unused)
    );

    spi_state_e           state, state_nxt;
    logic [1:0]           mode_q;       // {cpol, cpha} for the current frame
    logic                 lsbfe_q;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [7:0]           rx_shift;
    logic [7:0]           tx_shift;
    logic                 miso_r;
    logic [7:0]           hold_data;
    logic                 hold_full;

    logic       sample_edge, shift_edge;
    logic       start_frame, end_frame, sample_evt, shift_evt;
    logic       byte_done, load_shifter, tx_write;
    logic       eff_cpha, eff_lsbfe;
    logic [7:0] load_data, rx_next;

    // Sample on rising sclk when cpol == cpha, otherwise on falling sclk.
    always_comb begin
        sample_edge = 1'b0;
        shift_edge  = 1'b0;
        case (mode_q)
            MODE0, MODE3: begin
                sample_edge = sclk_rise;
                shift_edge  = sclk_fall;
            end
            default: begin
                sample_edge = sclk_fall;
                shift_edge  = sclk_rise;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        sample_evt  = 1'b0;
        shift_evt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_nxt   = ST_ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (ss_rise) begin
                    state_nxt = ST_IDLE;
                    end_frame = 1'b1;
                end else begin
                    sample_evt = sample_edge;
                    // With cpha=0 the first bit is already on miso after a
                    // load, so a shift edge at bit count 0 (before the first
                    // sample, or just after a byte wrap) must not advance it.
                    shift_evt  = shift_edge & (mode_q[0] | (bit_cnt != '0));
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign byte_done    = sample_evt & (bit_cnt == BIT_LAST);
    assign load_shifter = start_frame | byte_done;
    assign load_data    = hold_full ? hold_data : IDLE_FILL;
    assign tx_write     = tx_valid & ~hold_full;
    // On the entry cycle the mode registers are still being written.
    assign eff_cpha     = start_frame ? cpha  : mode_q[0];
    assign eff_lsbfe    = start_frame ? lsbfe : lsbfe_q;
    assign rx_next      = shift_in(rx_shift, mosi_s, lsbfe_q);

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            mode_q    <= MODE0;
            lsbfe_q   <= 1'b0;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            miso_r    <= 1'b0;
            hold_data <= '0;
            hold_full <= 1'b0;
        end else begin
            if (start_frame) begin
                mode_q  <= {cpol, cpha};
                lsbfe_q <= lsbfe;
            end

            if (start_frame || end_frame) begin
                bit_cnt  <= '0;
                rx_shift <= '0;
            end else if (sample_evt) begin
                bit_cnt  <= bit_cnt + 1'b1;
                rx_shift <= rx_next;
            end

            if (load_shifter) begin
                if (!eff_cpha) begin
                    miso_r   <= first_bit(load_data, eff_lsbfe);
                    tx_shift <= shift_out(load_data, eff_lsbfe);
                end else begin
                    // cpha=1: the first leading edge puts bit 0 on miso.
                    tx_shift <= load_data;
                    if (start_frame) miso_r <= 1'b0;
                end
            end else if (shift_evt) begin
                miso_r   <= first_bit(tx_shift, lsbfe_q);
                tx_shift <= shift_out(tx_shift, lsbfe_q);
            end

            // A write is only accepted while empty, so it never collides with
            // a load that drains the register; a load from an empty register
            // takes IDLE_FILL and the concurrent write is kept for next byte.
            if (tx_write) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end else if (load_shifter && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic rx_drop;
    assign rx_drop = byte_done & rx_valid & ~rx_ready;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (byte_done && !rx_drop) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (rx_drop)          rx_overrun <= 1'b1;
            else if (clr_overrun) rx_overrun <= 1'b0;
        end
    end
`else
    logic clr_overrun_unused;
    assign clr_overrun_unused = clr_overrun;
    assign rx_overrun         = 1'b0;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            if (byte_done) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end
`endif

    assign busy     = (state == ST_ACTIVE);
    assign miso_oe  = busy;
    assign miso     = busy & miso_r;
    assign tx_ready = ~hold_full;

endmodule

// File: tb/tb_spi_slave_port.sv
// tb_spi_slave_port: self-checking bench for spi_slave_port. A bus-functional
// SPI master drives the port; received bytes are checked by a scoreboard
// queue popped on each rx_valid/rx_ready handshake, and captured miso bytes
// are compared against the expected TX data.

module tb_spi_slave_port;

    localparam int HALF = 6;

    logic       PCLK = 1'b0;
    logic       PRESETn;
    logic       cpol, cpha, lsbfe;
    logic       sclk, ss, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic       rx_overrun, clr_overrun;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    int         rx_rises = 0;
    logic       rv_prev = 1'b0;
    logic [7:0] exp_q[$];

    spi_slave_port dut (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .cpol        (cpol),
        .cpha        (cpha),
        .lsbfe       (lsbfe),
        .sclk        (sclk),
        .ss          (ss),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_overrun  (rx_overrun),
        .clr_overrun (clr_overrun),
        .busy        (busy)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted RX byte must match the oldest expected one.
    always @(negedge PCLK) begin
        if (PRESETn && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h expected none", rx_data);
            end else begin
                check("rx_byte", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
            end
        end
        if (rx_valid && !rv_prev) rx_rises++;
        rv_prev = rx_valid;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic set_mode(input logic cp, input logic ch, input logic lb);
        cpol  = cp;
        cpha  = ch;
        lsbfe = lb;
        sclk  = cp;
        wait_clk(8);
    endtask

    task automatic write_tx(input logic [7:0] d);
        int n;
        n        = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 50) begin
            wait_clk(1);
            n++;
        end
        if (n >= 50) check("tx_ready_timeout", 32'd0, 32'd1);
        wait_clk(1);
        tx_valid = 1'b0;
    endtask

    task automatic frame_begin();
        ss = 1'b0;
        wait_clk(8);
    endtask

    task automatic frame_end();
        ss = 1'b1;
        wait_clk(8);
    endtask

    // Master side of one byte (or the first nbits of it).
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        int idx;
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            idx = lsbfe ? i : 7 - i;
            if (!cpha) begin
                mosi = mo[idx];
                wait_clk(HALF);
                sclk = ~cpol;
                mi[idx] = miso;
                wait_clk(HALF);
                sclk = cpol;
            end else begin
                wait_clk(HALF);
                sclk = ~cpol;
                mosi = mo[idx];
                wait_clk(HALF);
                sclk = cpol;
                mi[idx] = miso;
            end
        end
        wait_clk(HALF);
    endtask

    typedef struct {
        logic       cpol, cpha, lsbfe, has_tx;
        logic [7:0] tx, mo, exp_rx, exp_mi;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [7:0] cap, cap2;
        int         r0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h96, 8'h96, 8'hFF};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 8'h81, 8'h81, 8'hC3};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h5E, 8'hE7, 8'hE7, 8'h5E};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 8'h34, 8'h12};

        PRESETn = 1'b0;
        cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
        sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0;
        rx_ready = 1'b1; clr_overrun = 1'b0;
        wait_clk(3);
        check("rst_miso", {31'h0, miso}, 32'd0);
        check("rst_miso_oe", {31'h0, miso_oe}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_tx_ready", {31'h0, tx_ready}, 32'd1);
        check("rst_rx_valid", {31'h0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'h0, rx_data}, 32'h00);
        check("rst_rx_overrun", {31'h0, rx_overrun}, 32'd0);
        PRESETn = 1'b1;
        wait_clk(8);

        // Single-byte frames in every mode and bit order.
        for (int v = 0; v < 5; v++) begin
            set_mode(vecs[v].cpol, vecs[v].cpha, vecs[v].lsbfe);
            if (vecs[v].has_tx) write_tx(vecs[v].tx);
            else check("tx_ready_idle", {31'h0, tx_ready}, 32'd1);
            r0 = rx_rises;
            frame_begin();
            check("busy_in_frame", {31'h0, busy}, 32'd1);
            check("miso_oe_in_frame", {31'h0, miso_oe}, 32'd1);
            exp_q.push_back(vecs[v].exp_rx);
            xfer(vecs[v].mo, 8, cap);
            frame_end();
            check("miso_byte", {24'h0, cap}, {24'h0, vecs[v].exp_mi});
            check("rx_rise_count", r0 + 1, rx_rises);
            check("tx_ready_after", {31'h0, tx_ready}, 32'd1);
            check("busy_after", {31'h0, busy}, 32'd0);
        end

        // Back-to-back bytes, mode 3 LSB first, ss low throughout.
        set_mode(1'b1, 1'b1, 1'b1);
        write_tx(8'h01);
        frame_begin();
        write_tx(8'h80);
        exp_q.push_back(8'hF0);
        xfer(8'hF0, 8, cap);
        exp_q.push_back(8'h0F);
        xfer(8'h0F, 8, cap2);
        frame_end();
        check("b2b_miso0", {24'h0, cap}, 32'h01);
        check("b2b_miso1", {24'h0, cap2}, 32'h80);

        // Two bytes with rx_ready low.
        set_mode(1'b0, 1'b0, 1'b0);
        rx_ready = 1'b0;
        frame_begin();
        xfer(8'h11, 8, cap);
        xfer(8'h22, 8, cap);
        frame_end();
        check("ovr_rx_valid", {31'h0, rx_valid}, 32'd1);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("ovr_rx_data", {24'h0, rx_data}, 32'h11);
        check("ovr_flag_set", {31'h0, rx_overrun}, 32'd1);
        clr_overrun = 1'b1;
        wait_clk(1);
        clr_overrun = 1'b0;
        check("ovr_flag_clr", {31'h0, rx_overrun}, 32'd0);
        exp_q.push_back(8'h11);
`else
        check("ovr_rx_data", {24'h0, rx_data}, 32'h22);
        check("ovr_flag_off", {31'h0, rx_overrun}, 32'd0);
        exp_q.push_back(8'h22);
`endif
        rx_ready = 1'b1;
        wait_clk(3);
        check("ovr_rx_drained", {31'h0, rx_valid}, 32'd0);

        // ss raised mid-byte: partial byte discarded, holding register kept.
        write_tx(8'h77);
        r0 = rx_rises;
        frame_begin();
        write_tx(8'h66);
        xfer(8'hC3, 4, cap);
        frame_end();
        check("abort_partial_miso", {28'h0, cap[7:4]}, 32'h7);
        check("abort_no_rx", r0, rx_rises);
        check("abort_hold_kept", {31'h0, tx_ready}, 32'd0);
        exp_q.push_back(8'h5A);
        frame_begin();
        xfer(8'h5A, 8, cap);
        frame_end();
        check("abort_next_miso", {24'h0, cap}, 32'h66);
        check("abort_next_rx_count", r0 + 1, rx_rises);

        // Reset mid-byte with ss held low through and after reset.
        write_tx(8'h9C);
        frame_begin();
        write_tx(8'h44);
        xfer(8'hFF, 3, cap);
        PRESETn = 1'b0;
        wait_clk(1);
        check("mid_rst_busy", {31'h0, busy}, 32'd0);
        check("mid_rst_miso_oe", {31'h0, miso_oe}, 32'd0);
        check("mid_rst_miso", {31'h0, miso}, 32'd0);
        check("mid_rst_tx_ready", {31'h0, tx_ready}, 32'd1);
        check("mid_rst_rx_valid", {31'h0, rx_valid}, 32'd0);
        check("mid_rst_rx_data", {24'h0, rx_data}, 32'h00);
        check("mid_rst_rx_overrun", {31'h0, rx_overrun}, 32'd0);
        wait_clk(2);
        PRESETn = 1'b1;
        wait_clk(10);
        check("no_frame_without_fresh_ss", {31'h0, busy}, 32'd0);
        ss = 1'b1;
        wait_clk(8);
        write_tx(8'h3C);
        exp_q.push_back(8'hA5);
        frame_begin();
        xfer(8'hA5, 8, cap);
        frame_end();
        check("post_rst_miso", {24'h0, cap}, 32'h3C);

        wait_clk(4);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

SPI target (slave) port: the far end of the team's SPI master link. Receives `sclk`, `ss` and `mosi` from an external master, drives `miso`, and exchanges full bytes with local logic over valid/ready handshakes. All SPI inputs are oversampled in the `PCLK` domain; no logic is clocked by `sclk`. It sits beside the APB register block in designs where the chip is the controlled device instead of the controller.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `ss` and `mosi` (minimum 2).
- `IDLE_FILL`, 8'hFF: byte shifted out when no TX byte is pending (underrun).
- `PCLK` in 1: the only clock.
- `PRESETn` in 1: synchronous, active-low reset.
- `cpol`, `cpha`, `lsbfe` in 1 each: SPI mode and bit order, sampled at frame start.
- `sclk`, `ss`, `mosi` in 1 each: asynchronous SPI inputs; `ss` is active-low.
- `miso` out 1: serial data to the master.
- `miso_oe` out 1: high while the frame is active, for the pad tristate.
- `tx_data` in 8, `tx_valid` in 1, `tx_ready` out 1: TX holding register write handshake.
- `rx_data` out 8, `rx_valid` out 1, `rx_ready` in 1: received byte handshake.
- `rx_overrun` out 1: sticky overrun flag (only with `SPI_SLAVE_OVERRUN_EN`).
- `clr_overrun` in 1: clears `rx_overrun`.
- `busy` out 1: frame active (`ss` low after synchronization).

## Operation
- States are IDLE and ACTIVE. IDLE→ACTIVE on the synchronized `ss` falling edge. ACTIVE→IDLE on the synchronized `ss` rising edge.
- On IDLE→ACTIVE:
  - `cpol`, `cpha` and `lsbfe` are latched for the whole frame.
  - The bit counter is cleared.
  - The shifter is loaded from the holding register, or from `IDLE_FILL` if the holding register is empty.
- Leading edge is rising when `cpol`=0 and falling when `cpol`=1. The sample edge is the leading edge when `cpha`=0 and the trailing edge when `cpha`=1; the other edge is the shift edge.
- `cpha`=0: the first bit is on `miso` from the ACTIVE entry cycle. A shift edge before the first sample edge is ignored.
- `cpha`=1: the first shift edge drives bit 0.
- Bit order: MSB first when `lsbfe`=0, LSB first when `lsbfe`=1, in both directions.
- On the 8th sample edge:
  - The RX byte completes.
  - The counter wraps to 0.
  - The shifter reloads from holding or `IDLE_FILL` for the next byte, which allows back-to-back bytes without an `ss` toggle.
- TX holding register:
  - One entry. `tx_ready`=1 when empty; a write is accepted on `tx_valid & tx_ready`.
  - Emptied when the shifter loads from it.
  - A write in the same cycle as a shifter load lands in the holding register for the next byte; the shifter takes the prior contents.
- RX: the completed byte goes to `rx_data` and `rx_valid` is set. `rx_valid` clears on `rx_valid & rx_ready`. Completion and acceptance in the same cycle: the new byte is latched, `rx_valid` stays 1, no overrun.
- `ss` deasserted mid-byte:
  - The partial RX byte is discarded and `rx_valid` is not set.
  - The counter clears.
  - A TX byte already loaded into the shifter is lost.
  - The holding register is kept.
- `miso_oe`=`busy`. `miso`=0 in IDLE.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `busy`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=8'h00, `rx_overrun`=0, holding register empty, state IDLE.
- Input latency is `SYNC_STAGES` cycles plus 1 edge-detect cycle, i.e. 3 `PCLK` with the default.
- `sclk` high and low phases must each be at least 4 `PCLK`. The master must hold `ss` low for at least 4 `PCLK` before the first `sclk` edge.
- `rx_valid` rises 1 `PCLK` after the detected 8th sample edge.
- `miso` updates 1 `PCLK` after the detected shift edge.
- `busy` rises 1 `PCLK` after the detected `ss` fall.
- Reset asserted mid-frame: every output returns to its reset value on the next `PCLK`. After reset, a frame begins only on a fresh `ss` falling edge.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined:
  - A byte completing while `rx_valid`=1 (and not accepted that cycle) is dropped; `rx_data` is unchanged.
  - `rx_overrun` is set and stays set until `clr_overrun`.
  - If set and clear coincide, set wins.
- Not defined:
  - The new byte overwrites `rx_data` and `rx_valid` stays 1.
  - `rx_overrun` is tied to 0 and `clr_overrun` is ignored.

## Structure
- Package `spi_pkg`: the IDLE/ACTIVE state enum, mode encoding constants (`MODE0`..`MODE3`), `BIT_CNT_W`=3, and the default `SYNC_STAGES`.
- Sub-module `spi_input_sync`: a `SYNC_STAGES` flop chain plus rise/fall pulse outputs. Instanced for `sclk` and `ss`; `mosi` uses the level output only.

## Test plan
- Mode 0, MSB first, `tx_data`=8'hA5 preloaded; master sends 8'h3C → `rx_data`=8'h3C with a single `rx_valid` rise, and the master captures 8'hA5.
- Mode 3, `lsbfe`=1, two back-to-back bytes with `ss` low throughout, TX 8'h01 then 8'h80; master sends 8'hF0, 8'h0F → both RX bytes arrive in order and the master captures 8'h01, 8'h80.
- No TX write before the frame, mode 1 → master captures 8'hFF and `tx_ready` stays 1.
- Two bytes received with `rx_ready`=0 → with the macro: `rx_data` holds the first byte and `rx_overrun`=1, and `clr_overrun` clears it. Without the macro: `rx_data`=second byte and `rx_overrun`=0.
- `ss` raised after 4 `sclk` cycles, then a full frame sending 8'h5A → no `rx_valid` for the partial byte, then `rx_data`=8'h5A.
- `PRESETn` low mid-byte → all outputs at reset values next cycle, and the following frame completes correctly.
